// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined)
module uart_tx_fifo #(
    parameter int CLOCKS_PER_BAUD = 868,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] axiid,
    input  logic       axiiv,
    output logic       axiir,
    output logic       tx,
    output logic       busy
);

    localparam int BW = $clog2(CLOCKS_PER_BAUD);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLOCKS_PER_BAUD - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
`ifdef UART_TX_PARITY_EN
    logic          parity_bit;
`endif
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          baud_wrap;
    logic          idle_next;
    logic          tx_next;

    always_comb begin
        push       = axiiv && axiir;
        fifo_empty = (count == '0);
        baud_wrap  = (baud == BAUD_LAST);
        // Both pop points coincide with the points where the FSM could fall back to IDLE.
        pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_wrap));
        idle_next  = fifo_empty && ((state == IDLE) || ((state == STOP) && baud_wrap));
        count_next = count + (AW+1)'(push) - (AW+1)'(pop);
        tx_next    = 1'b1;
        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_bit;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= axiid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
            tx         <= 1'b1;
            axiir      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            // One dead cycle after each accept so a registered producer is never sampled twice.
            axiir <= !push && (count_next != FULL_COUNT);
            busy  <= (count_next != '0) || !idle_next;
            tx    <= tx_next;

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift_reg  <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^mem[rd_ptr];
`endif
                        baud       <= '0;
                        state      <= START;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        baud      <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_wrap) begin
                        baud  <= '0;
                        state <= STOP;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_wrap) begin
                        baud <= '0;
                        if (!fifo_empty) begin
                            shift_reg  <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^mem[rd_ptr];
`endif
                            state      <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed vector bench for uart_tx_fifo at CLOCKS_PER_BAUD=4
module tb_uart_tx_fifo;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] axiid;
    logic       axiiv;
    logic       axiir;
    logic       tx;
    logic       busy;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    uart_tx_fifo #(.CLOCKS_PER_BAUD(CPB), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axiid (axiid),
        .axiiv (axiiv),
        .axiir (axiir),
        .tx    (tx),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [FB-1:0] mk_exp(input logic [9:0] f, input logic p);
`ifdef UART_TX_PARITY_EN
        return {f[9], p, f[8:0]};
`else
        logic unused;
        unused = p;
        return f;
`endif
    endfunction

    task automatic push(input logic [7:0] d, output int acc);
        int n;
        n = 0;
        axiid = d;
        axiiv = 1'b1;
        while (!axiir && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!axiir) begin
            check("push_timeout", 0, 1);
            axiiv = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        @(negedge clk);
        axiiv = 1'b0;
    endtask

    task automatic rx_frame(output logic [FB-1:0] bits, output int start_cyc);
        int n;
        n = 0;
        bits = '0;
        start_cyc = -1;
        @(negedge clk);
        while (tx !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            check("rx_timeout", 0, 1);
            return;
        end
        start_cyc = cyc;
        repeat (CPB/2) @(negedge clk);
        bits[0] = tx;
        for (int i = 1; i < FB; i++) begin
            repeat (CPB) @(negedge clk);
            bits[i] = tx;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_axiir", int'(axiir), 0);
        check("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("axiir_after_reset", int'(axiir), 1);
    endtask

    vec_t        vecs [7];
    logic [7:0]  s2 [4];
    logic [9:0]  s2_frame [4];
    logic        s2_par [4];
    logic [9:0]  s3_frame [6];
    logic        s3_par [6];
    int          s3_acc_off [6];
    logic [FB-1:0] bits;
    logic [FB-1:0] b_arr [6];
    int          st_arr [6];
    int          acc_arr [6];
    int          acc;
    int          st;
    int          bad;
    int          idx;
    logic [6:0]  pat;

    initial begin
        vecs[0] = '{8'h4D, 10'h29A, 1'b0};
        vecs[1] = '{8'h00, 10'h200, 1'b0};
        vecs[2] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[3] = '{8'h55, 10'h2AA, 1'b0};
        vecs[4] = '{8'h0A, 10'h214, 1'b0};
        vecs[5] = '{8'h80, 10'h300, 1'b1};
        vecs[6] = '{8'h07, 10'h20E, 1'b1};
        s2       = '{8'h4D, 8'h30, 8'h0D, 8'h0A};
        s2_frame = '{10'h29A, 10'h260, 10'h21A, 10'h214};
        s2_par   = '{1'b0, 1'b0, 1'b1, 1'b0};
        s3_frame = '{10'h282, 10'h284, 10'h286, 10'h288, 10'h28A, 10'h28C};
        s3_par   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        s3_acc_off = '{0, 2, 4, 6, 8, 2 + FB*CPB};

        rst_n = 1'b0;
        axiiv = 1'b0;
        axiid = 8'h00;
        do_reset();

        // Idle after reset: ready held, line high, not busy.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (axiir !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("idle_100_bad_cycles", bad, 0);

        // Single-frame vectors: latency, frame bits, busy fall time.
        for (int v = 0; v < 7; v++) begin
            push(vecs[v].data, acc);
            rx_frame(bits, st);
            check($sformatf("latency_%0h", vecs[v].data), st - acc, 2);
            check($sformatf("frame_%0h", vecs[v].data), int'(bits), int'(mk_exp(vecs[v].frame, vecs[v].par)));
            while (cyc < acc + FB*CPB) @(negedge clk);
            check($sformatf("busy_hold_%0h", vecs[v].data), int'(busy), 1);
            @(negedge clk);
            check($sformatf("busy_fall_%0h", vecs[v].data), int'(busy), 0);
            check($sformatf("tx_idle_%0h", vecs[v].data), int'(tx), 1);
            repeat (3) @(negedge clk);
        end

        // Streaming with valid held high: ready toggles, frames back-to-back.
        fork
            begin
                idx = 0;
                axiiv = 1'b1;
                axiid = s2[0];
                for (int k = 0; k < 7; k++) begin
                    pat[k] = axiir;
                    if (axiir) begin
                        acc_arr[idx] = cyc + 1;
                        idx++;
                    end
                    @(negedge clk);
                    if (idx < 4) axiid = s2[idx];
                end
                axiiv = 1'b0;
            end
            begin
                for (int f = 0; f < 4; f++) rx_frame(b_arr[f], st_arr[f]);
            end
        join
        check("stream_axiir_pattern", int'(pat), 32'h55);
        check("stream_latency", st_arr[0] - acc_arr[0], 2);
        for (int f = 0; f < 4; f++) begin
            check($sformatf("stream_frame_%0d", f), int'(b_arr[f]), int'(mk_exp(s2_frame[f], s2_par[f])));
            if (f > 0) check($sformatf("stream_gap_%0d", f), st_arr[f] - st_arr[f-1], FB*CPB);
        end
        wait_idle();

        // Overfill: ready stays low while four bytes are queued, nothing lost.
        fork
            begin
                for (int i = 0; i < 6; i++) push(8'h41 + 8'(i), acc_arr[i]);
            end
            begin
                for (int i = 0; i < 6; i++) rx_frame(b_arr[i], st_arr[i]);
            end
        join
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fill_accept_%0d", i), acc_arr[i] - acc_arr[0], s3_acc_off[i]);
            check($sformatf("fill_frame_%0d", i), int'(b_arr[i]), int'(mk_exp(s3_frame[i], s3_par[i])));
            if (i > 0) check($sformatf("fill_gap_%0d", i), st_arr[i] - st_arr[i-1], FB*CPB);
        end
        wait_idle();

        // Reset during DATA of 0x55 with two bytes queued.
        push(8'h55, acc);
        push(8'h33, st);
        push(8'h44, st);
        while (cyc < acc + 12) @(negedge clk);
        check("mid_data_tx", int'(tx), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_tx", int'(tx), 1);
        check("async_reset_axiir", int'(axiir), 0);
        check("async_reset_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || axiir !== 1'b1) bad++;
            @(negedge clk);
        end
        check("post_reset_no_stale", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
